line_draw_engine: RTL
=====================

Name: line_draw_engine

Overview:
- Bresenham line rasteriser directly downstream of the Avalon line-drawing slave controller.
- Consumes the controller's go/colour/x0/y0/x1/y1 outputs and drives one pixel write per clock into the VGA adapter (plot/x/y/colour).
- Returns done to the controller, which uses it for waitrequest stalling (mode 0) and status polling (mode 1).

Parameters:
- XW, 9, x coordinate width (0..511)
- YW, 8, y coordinate width (0..255)
- CW, 3, colour width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- go  in  1  level request from controller; held high until controller sees done
- colour  in  CW  line colour
- x0  in  XW  start x
- y0  in  YW  start y
- x1  in  XW  end x
- y1  in  YW  end y
- done  out  1  line complete, held until go drops
- plot  out  1  VGA write enable, one pixel per cycle
- x  out  XW  pixel x
- y  out  YW  pixel y
- colour_out  out  CW  pixel colour

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, done=0, plot=0, x=0, y=0, colour_out=0. Reset overrides everything, including mid-line; no further pixels are plotted.
- States: IDLE, LOAD, DRAW, DONE.
- IDLE: plot=0, done=0. If go==1 at the edge:
  - latch x0, y0, x1, y1 and colour;
  - next state LOAD.
- LOAD (one cycle, plot=0):
  - dx = |x1-x0|, dy = -|y1-y0|;
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1;
  - err = dx+dy;
  - cur = (x0,y0);
  - next state DRAW.
- DRAW, each cycle:
  - plot=1, x/y=cur, colour_out=latched colour.
  - If cur==(x1,y1): next state DONE.
  - Else e2=2*err:
    - if e2>=dy: err+=dy, cur.x+=sx;
    - if e2<=dx: err+=dx, cur.y+=sy;
    - both updates use the pre-update err in the same cycle.
- DONE: plot=0, done=1.
  - Stay while go==1.
  - When go==0, next state IDLE, so done deasserts the following cycle.
  - done is high for at least one cycle even if go already dropped.
- Latency:
  - go sampled high at edge N; LOAD during cycle N+1; first plot cycle N+2.
  - Exactly max(|dx|,|dy|)+1 plot cycles.
  - done rises on the cycle after the last plot.
- Arithmetic:
  - dx is unsigned XW bits, dy signed YW+1 bits.
  - err is signed XW+3 bits (range -(2^YW) .. 2*(2^XW)); e2 is one bit wider.
  - No overflow is possible for any input.
- Coordinates are never clipped. The engine plots only pixels on the segment; screen bounds are the controller/software's responsibility.
- go falling during LOAD/DRAW is ignored; the line completes.
- go rising in DONE or IDLE with new coordinates: taken only from IDLE. A fresh line requires go to drop, a return to IDLE, then go high again.
- Single point (x0==x1, y0==y1): exactly one plot cycle, then DONE.
- Inputs are sampled only in IDLE. Changes during a draw have no effect.

Test Plan:
- Horizontal: go with (0,0)->(3,0), colour 3'b100 -> plot high 4 consecutive cycles starting 2 cycles after go; pixels (0,0),(1,0),(2,0),(3,0), colour_out=4; done=1 next cycle; done holds while go high; done=0 one cycle after go=0.
- Reverse diagonal: (10,10)->(7,7) -> pixels (10,10),(9,9),(8,8),(7,7); 4 plots; done follows.
- Steep: (5,0)->(6,4) -> 5 plots, y=0,1,2,3,4 strictly incrementing by 1; x non-decreasing 5..6; last (6,4).
- Single point: (100,50)->(100,50) -> exactly one plot at (100,50), then done.
- Full diagonal: (0,0)->(319,239) -> 320 plot cycles; first (0,0), last (319,239); every step |dx|<=1, |dy|<=1; no repeated pixel.
- Reset mid-draw and go handling:
  - reset=0 on the 3rd plot cycle of (0,0)->(9,0) -> next cycle plot=0, done=0, x=0, y=0, state IDLE.
  - With go still high after reset release, a new line starts from the inputs then present.
  - Separately, go dropping mid-line still yields all 10 pixels and a one-cycle done pulse.

Source files
------------

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser. Takes a go/colour/endpoint request from the line
// controller, emits one pixel write per clock toward the VGA adapter, and
// raises done once the segment is finished until go is released.
module line_draw_engine #(
  parameter int XW = 9,
  parameter int YW = 8,
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  input  logic [CW-1:0] colour,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic          done,
  output logic          plot,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour_out
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t state;

  // Request latched in IDLE; later input changes never reach the datapath.
  logic [XW-1:0] lx0, lx1;
  logic [YW-1:0] ly0, ly1;
  logic [CW-1:0] lcol;

  // Bresenham working set. x/y outputs double as the current pixel.
  logic [XW-1:0]        dx;
  logic signed [YW:0]   dy;
  logic                 xneg;
  logic                 yneg;
  logic signed [XW+2:0] err;

  // Set-up values computed from the latched endpoints during LOAD.
  logic [XW-1:0]        load_dx;
  logic [YW-1:0]        load_ady;
  logic signed [YW:0]   load_dy;
  logic signed [XW+2:0] load_dy_w;
  logic signed [XW+2:0] load_err;

  // Per-step decision values for DRAW.
  logic signed [XW+3:0] e2;
  logic signed [XW+3:0] dx_e;
  logic signed [XW+3:0] dy_e;
  logic signed [XW+2:0] dx_w;
  logic signed [XW+2:0] dy_w;
  logic signed [XW+2:0] err_next;
  logic                 step_x;
  logic                 step_y;
  logic                 at_end;

  // Absolute deltas, initial error and the next-step decision for the current pixel.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    load_dx   = (lx1 >= lx0) ? (lx1 - lx0) : (lx0 - lx1);
    load_ady  = (ly1 >= ly0) ? (ly1 - ly0) : (ly0 - ly1);
    load_dy   = -$signed({1'b0, load_ady});
    load_dy_w = load_dy;
    load_err  = $signed({3'b000, load_dx}) + load_dy_w;

    e2   = err;
    e2   = e2 <<< 1;
    dx_e = $signed({4'b0000, dx});
    dy_e = dy;
    dx_w = $signed({3'b000, dx});
    dy_w = dy;

    step_x = (e2 >= dy_e);
    step_y = (e2 <= dx_e);

    // Both corrections are based on the error value from before this step.
    err_next = err;
    if (step_x) err_next = err_next + dy_w;
    if (step_y) err_next = err_next + dx_w;

    at_end = (x == lx1) && (y == ly1);
  end

  // Control FSM with registered pixel/done outputs.
  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state      <= IDLE;
      done       <= 1'b0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (go) begin
            lx0   <= x0;
            ly0   <= y0;
            lx1   <= x1;
            ly1   <= y1;
            lcol  <= colour;
            state <= LOAD;
          end
        end
        LOAD: begin
          dx         <= load_dx;
          dy         <= load_dy;
          xneg       <= !(lx0 < lx1);
          yneg       <= !(ly0 < ly1);
          err        <= load_err;
          x          <= lx0;
          y          <= ly0;
          colour_out <= lcol;
          plot       <= 1'b1;
          state      <= DRAW;
        end
        DRAW: begin
          if (at_end) begin
            plot  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            err <= err_next;
            if (step_x) x <= xneg ? (x - 1'b1) : (x + 1'b1);
            if (step_y) y <= yneg ? (y - 1'b1) : (y + 1'b1);
          end
        end
        DONE: begin
          plot <= 1'b0;
          if (!go) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: the endpoint latches and Bresenham registers are left out of reset; each is written before it is read.

endmodule
